// File: rtl/hazard_ctrl_if.sv
// Decode-side hazard interface: decode operand/destination info and branch
// resolution in, stall/flush/forward controls and perf counters out.
interface hazard_ctrl_if #(
  parameter int RA_W  = 4,
  parameter int CNT_W = 16
);
  logic             valid_D;
  logic [RA_W-1:0]  RA1_D;
  logic [RA_W-1:0]  RA2_D;
  logic             use1_D;
  logic             use2_D;
  logic [RA_W-1:0]  WA_D;
  logic             RegWrite_D;
  logic             MemtoReg_D;
  logic             BranchTaken_E;
  logic             StallF;
  logic             StallD;
  logic             FlushD;
  logic             FlushE;
  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output valid_D, RA1_D, RA2_D, use1_D, use2_D, WA_D, RegWrite_D, MemtoReg_D, BranchTaken_E,
    input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, stall_cnt, flush_cnt
  );

  modport slave (
    input  valid_D, RA1_D, RA2_D, use1_D, use2_D, WA_D, RegWrite_D, MemtoReg_D, BranchTaken_E,
    output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core. Shadows destination info for E/M/W,
// detects load-use and taken-branch hazards, selects execute-operand forwarding
// and counts stall cycles and flushes with saturating counters.
module hazard_ctrl #(
  parameter int RA_W   = 4,
  parameter int PC_REG = 15,
  parameter int CNT_W  = 16
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave hz
);
  localparam logic [RA_W-1:0] PC_IDX = RA_W'(PC_REG);

  logic             vE, rwE, m2rE, u1E, u2E;
  logic [RA_W-1:0]  rdE, ra1E, ra2E;
  logic             vM, rwM, m2rM;
  logic [RA_W-1:0]  rdM;
  logic             vW, rwW;
  logic [RA_W-1:0]  rdW;
  logic             lduse, br, flush_e;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // Hazard detection; R15 is PC and never counts as a load destination.
  always_comb begin
    lduse = vE & rwE & m2rE & (rdE != PC_IDX) & hz.valid_D &
            ((hz.use1_D & (hz.RA1_D == rdE)) | (hz.use2_D & (hz.RA2_D == rdE)));
    br    = vE & hz.BranchTaken_E;
  end

  // Stall/flush controls; a taken branch squashes whatever sits in D, so it wins.
  always_comb begin
    hz.StallF = 1'b0;
    hz.StallD = 1'b0;
    hz.FlushD = 1'b0;
    flush_e   = 1'b0;
    if (br) begin
      hz.FlushD = 1'b1;
      flush_e   = 1'b1;
    end else if (lduse) begin
      hz.StallF = 1'b1;
      hz.StallD = 1'b1;
      flush_e   = 1'b1;
    end
    hz.FlushE = flush_e;
  end

  // Operand forwarding; M beats W, and a load in M has no data yet.
  always_comb begin
    hz.ForwardAE = 2'b00;
    hz.ForwardBE = 2'b00;
    if (u1E && (ra1E != PC_IDX)) begin
      if (vM && rwM && !m2rM && (rdM == ra1E))  hz.ForwardAE = 2'b10;
      else if (vW && rwW && (rdW == ra1E))      hz.ForwardAE = 2'b01;
    end
    if (u2E && (ra2E != PC_IDX)) begin
      if (vM && rwM && !m2rM && (rdM == ra2E))  hz.ForwardBE = 2'b10;
      else if (vW && rwW && (rdW == ra2E))      hz.ForwardBE = 2'b01;
    end
  end

  // Shadow pipeline; a flushed D->E transfer becomes a bubble but keeps its fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vE <= 1'b0; rwE <= 1'b0; m2rE <= 1'b0; u1E <= 1'b0; u2E <= 1'b0;
      rdE <= '0; ra1E <= '0; ra2E <= '0;
      vM <= 1'b0; rwM <= 1'b0; m2rM <= 1'b0; rdM <= '0;
      vW <= 1'b0; rwW <= 1'b0; rdW <= '0;
    end else begin
      vE   <= hz.valid_D & ~flush_e;
      rdE  <= hz.WA_D;
      rwE  <= hz.RegWrite_D;
      m2rE <= hz.MemtoReg_D;
      ra1E <= hz.RA1_D;
      ra2E <= hz.RA2_D;
      u1E  <= hz.use1_D;
      u2E  <= hz.use2_D;
      vM   <= vE;
      rdM  <= rdE;
      rwM  <= rwE;
      m2rM <= m2rE;
      vW   <= vM;
      rdW  <= rdM;
      rwW  <= rwM;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (lduse && !br && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (br && (flush_cnt_q != '1))           flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage core (F/D/E/M/W) that sits beside the decode stage.
- Keeps a shadow of the register-destination information for the E, M and W stages.
- Generates forwarding selects for the execute operand muxes, and stall/flush controls for the load-use and taken-branch cases.
- Keeps saturating performance counters for stall cycles and flush events.

Parameters:
- RA_W, 4, register-address width (16 registers).
- PC_REG, 15, register index aliased to PC; never forwarded and never a hazard source.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; decided: asynchronous, active-high, all state cleared.
- valid_D  in  1  the decode stage holds a real instruction.
- RA1_D  in  RA_W  decode read address 1.
- RA2_D  in  RA_W  decode read address 2.
- use1_D  in  1  the instruction reads RA1_D.
- use2_D  in  1  the instruction reads RA2_D.
- WA_D  in  RA_W  decode destination register.
- RegWrite_D  in  1  the instruction writes WA_D.
- MemtoReg_D  in  1  the instruction is a load.
- BranchTaken_E  in  1  the instruction in E resolved as a taken branch.
- StallF  out  1  hold PC.
- StallD  out  1  hold the F/D register.
- FlushD  out  1  clear the F/D register.
- FlushE  out  1  insert a bubble into the D/E register.
- ForwardAE  out  2  operand A select: 00 = register file, 01 = W result, 10 = M ALU result.
- ForwardBE  out  2  operand B select, same encoding as ForwardAE.
- stall_cnt  out  CNT_W  number of load-use stall cycles.
- flush_cnt  out  CNT_W  number of taken-branch flushes.

Behaviour:
- Shadow state, updated on the clk rising edge:
  - E stage: vE, rdE, rwE, m2rE, ra1E, ra2E, u1E, u2E.
  - M stage: vM, rdM, rwM, m2rM.
  - W stage: vW, rdW, rwW.
- Reset (async): all v* = 0, fields = 0, counters = 0. Hence StallF/StallD/FlushD/FlushE = 0 and ForwardAE/ForwardBE = 00 while rst is high.
- Every cycle M->W and E->M advance unconditionally.
- D->E: the E shadow loads the decode inputs with vE <= valid_D & ~FlushE. When FlushE=1 the loaded entry is invalid (bubble).
- lduse (combinational) = vE & rwE & m2rE & rdE != PC_REG & valid_D & ((use1_D & RA1_D == rdE) | (use2_D & RA2_D == rdE)).
- br (combinational) = vE & BranchTaken_E.
- Priority: br overrides lduse.
  - br: FlushD = 1, FlushE = 1, StallF = 0, StallD = 0.
  - else lduse: StallF = 1, StallD = 1, FlushE = 1, FlushD = 0.
  - else all four = 0.
- Stall/flush outputs are combinational from the current shadow state and the D inputs; zero-cycle latency.
- Forwarding for operand A (combinational):
  - ForwardAE = 10 if u1E & vM & rwM & ~m2rM & rdM == ra1E & ra1E != PC_REG;
  - else 01 if u1E & vW & rwW & rdW == ra1E & ra1E != PC_REG;
  - else 00.
  - M has priority over W (newest value wins).
- Forwarding for operand B: identical rule using u2E/ra2E.
- A load in M is never forwarded from M. This cannot occur after a correct stall, but the ~m2rM term enforces it.
- Counters (CNT_W bits, saturate at all-ones, no wrap):
  - stall_cnt += 1 on each clock with lduse & ~br.
  - flush_cnt += 1 on each clock with br.
- Back-to-back case: a load-use stall resolves after exactly 1 bubble. Next cycle the load is in M, so lduse = 0 and the dependent instruction forwards from W two cycles later.
- Simultaneous br and lduse: only the flush happens and only flush_cnt increments.
- Reset mid-stall: outputs drop to 0 asynchronously and the pipeline restarts with an empty shadow.

Test Plan:
- Reset: assert rst mid-run with lduse active -> all outputs 0 immediately; counters 0 after release.
- ALU chain: ADD R3 then SUB R4,R3,R5 -> with SUB in E, ForwardAE = 10; an instruction reading R3 two slots later gets ForwardAE = 01; no stall.
- Load-use: LDR R2 then ADD R6,R2,R1 -> exactly 1 cycle of StallF = StallD = FlushE = 1; stall_cnt = 1; the ADD later sees ForwardAE = 01.
- Taken branch in E while a load-use is also detected in D -> FlushD = FlushE = 1, StallF = 0; flush_cnt = 1, stall_cnt unchanged.
- PC alias: producer writes R15 and consumer reads R15 -> ForwardAE/ForwardBE = 00 and no stall; both M and W write R7 with a reader of R7 -> 10 (M priority).
- Saturation: force 2^16 + 3 stall cycles -> stall_cnt holds at 16'hFFFF.
